// File: rtl/regbank_writeback.sv
// Writeback stage feeding the register bank's toggle-triggered write port.
// Optional forwarding search enabled with `define REGBANK_WB_FORWARD_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a FIFO entry; loads head addr/data when one exists
// SETUP | addr/data stable; toggles trigger, loads CPSR, pops the head
// HOLD  | addr/data held HOLD_CYCLES cycles after the trigger edge
module regbank_writeback #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        res_valid,
   output logic        res_ready,
   input  logic        res_wr_en,
   input  logic [3:0]  res_addr,
   input  logic [31:0] res_data,
   input  logic        res_cpsr_we,
   input  logic [31:0] res_cpsr,
   output logic        wb_trigger,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] cpsr_out,
   output logic        pc_wr,
   output logic [15:0] busy_mask,
   output logic        idle
`ifdef REGBANK_WB_FORWARD_EN
   ,
   input  logic [3:0]  fwd_addr,
   output logic        fwd_hit,
   output logic [31:0] fwd_data
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           ready_q, ready_d;
   logic           trig_q, trig_d;
   logic           pc_wr_q, pc_wr_d;
   logic [3:0]     wb_addr_q, wb_addr_d;
   logic [31:0]    wb_data_q, wb_data_d;
   logic [31:0]    cpsr_q, cpsr_d;
   logic [HW-1:0]  hold_q, hold_d;

   logic           mem_wr_en_q   [DEPTH];
   logic [3:0]     mem_addr_q    [DEPTH];
   logic [31:0]    mem_data_q    [DEPTH];
   logic           mem_cpsr_we_q [DEPTH];
   logic [31:0]    mem_cpsr_q    [DEPTH];

   logic           push, pop;
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]  offs;

   // Entries that neither write a register nor CPSR are dropped at the door.
   assign push = res_valid && ready_q && (res_wr_en || res_cpsr_we);

   always_comb begin
      valid = '0;
      offs  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs     = PW'(i) - rd_ptr_q;
         valid[i] = ({1'b0, offs} < count_q);
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && mem_wr_en_q[i]) begin
            busy_mask[mem_addr_q[i]] = 1'b1;
         end
      end
   end

`ifdef REGBANK_WB_FORWARD_EN
   logic [PW-1:0] fidx;

   // Walk oldest to newest so the entry nearest the tail wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fidx     = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fidx = rd_ptr_q + PW'(k);
         if ((CW'(k) < count_q) && mem_wr_en_q[fidx] && (mem_addr_q[fidx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_data_q[fidx];
         end
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      trig_d    = trig_q;
      pc_wr_d   = 1'b0;
      cpsr_d    = cpsr_q;
      hold_d    = hold_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               wb_addr_d = mem_addr_q[rd_ptr_q];
               wb_data_d = mem_data_q[rd_ptr_q];
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            pop = 1'b1;
            if (mem_cpsr_we_q[rd_ptr_q]) begin
               cpsr_d = mem_cpsr_q[rd_ptr_q];
            end
            if (mem_wr_en_q[rd_ptr_q]) begin
               trig_d  = ~trig_q;
               pc_wr_d = (mem_addr_q[rd_ptr_q] == 4'hF);
               hold_d  = HOLD_LAST;
               state_d = ST_HOLD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (hold_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      ready_d = (count_d != DEPTH_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ready_q   <= 1'b1;
         trig_q    <= 1'b0;
         pc_wr_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         cpsr_q    <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ready_q   <= ready_d;
         trig_q    <= trig_d;
         pc_wr_q   <= pc_wr_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         cpsr_q    <= cpsr_d;
         hold_q    <= hold_d;
      end
   end

   // Payload storage needs no reset; validity comes from the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wr_en_q[wr_ptr_q]   <= res_wr_en;
         mem_addr_q[wr_ptr_q]    <= res_addr;
         mem_data_q[wr_ptr_q]    <= res_data;
         mem_cpsr_we_q[wr_ptr_q] <= res_cpsr_we;
         mem_cpsr_q[wr_ptr_q]    <= res_cpsr;
      end
   end

   assign res_ready  = ready_q;
   assign wb_trigger = trig_q;
   assign wb_addr    = wb_addr_q;
   assign wb_data    = wb_data_q;
   assign cpsr_out   = cpsr_q;
   assign pc_wr      = pc_wr_q;
   assign idle       = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_regbank_writeback.sv
// Directed bench for regbank_writeback with hand-computed expectations.
// Forwarding checks compile in with `define REGBANK_WB_FORWARD_EN.
module tb_regbank_writeback;

   logic        clk;
   logic        rst_n;
   logic        res_valid;
   logic        res_ready;
   logic        res_wr_en;
   logic [3:0]  res_addr;
   logic [31:0] res_data;
   logic        res_cpsr_we;
   logic [31:0] res_cpsr;
   logic        wb_trigger;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] cpsr_out;
   logic        pc_wr;
   logic [15:0] busy_mask;
   logic        idle;
`ifdef REGBANK_WB_FORWARD_EN
   logic [3:0]  fwd_addr;
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int checks   = 0;
   int failures = 0;

   regbank_writeback #(.DEPTH(4), .HOLD_CYCLES(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_wr_en   (res_wr_en),
      .res_addr    (res_addr),
      .res_data    (res_data),
      .res_cpsr_we (res_cpsr_we),
      .res_cpsr    (res_cpsr),
      .wb_trigger  (wb_trigger),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .cpsr_out    (cpsr_out),
      .pc_wr       (pc_wr),
      .busy_mask   (busy_mask),
      .idle        (idle)
`ifdef REGBANK_WB_FORWARD_EN
      ,
      .fwd_addr    (fwd_addr),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Trigger-edge log, sampled on the falling edge.
   int          ncyc = 0;
   logic        trig_prev = 1'b0;
   int          tog_cyc  [$];
   logic [31:0] tog_data [$];
   logic [3:0]  tog_addr [$];
   logic [15:0] tog_busy [$];
   logic        tog_pc   [$];

   always @(negedge clk) begin
      ncyc++;
      if (rst_n && (wb_trigger !== trig_prev)) begin
         tog_cyc.push_back(ncyc);
         tog_data.push_back(wb_data);
         tog_addr.push_back(wb_addr);
         tog_busy.push_back(busy_mask);
         tog_pc.push_back(pc_wr);
      end
      trig_prev = wb_trigger;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_res(input logic v, input logic we, input logic [3:0] a,
                          input logic [31:0] d, input logic cwe, input logic [31:0] c);
      res_valid   = v;
      res_wr_en   = we;
      res_addr    = a;
      res_data    = d;
      res_cpsr_we = cwe;
      res_cpsr    = c;
   endtask

   task automatic clear_log;
      tog_cyc.delete();
      tog_data.delete();
      tog_addr.delete();
      tog_busy.delete();
      tog_pc.delete();
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (!idle && n < max_cyc) begin
         tick();
         n++;
      end
      chk("idle_timeout", {31'd0, idle}, 32'd1);
   endtask

   int  acc_tick [6];
   int  step;
   logic acc_now;
   logic accepted;

   initial begin
      rst_n = 1'b0;
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
`ifdef REGBANK_WB_FORWARD_EN
      fwd_addr = 4'd0;
`endif
      tick();
      tick();
      chk("rst_trigger",  {31'd0, wb_trigger}, 32'd0);
      chk("rst_addr",     {28'd0, wb_addr}, 32'd0);
      chk("rst_data",     wb_data, 32'd0);
      chk("rst_cpsr",     cpsr_out, 32'd0);
      chk("rst_pc_wr",    {31'd0, pc_wr}, 32'd0);
      chk("rst_busy",     {16'd0, busy_mask}, 32'd0);
      chk("rst_ready",    {31'd0, res_ready}, 32'd1);
      chk("rst_idle",     {31'd0, idle}, 32'd1);
      rst_n = 1'b1;
      tick();
      tick();

      // Single write r3=0xAA: load at E1, toggle at E2
      set_res(1'b1, 1'b1, 4'd3, 32'h0000_00AA, 1'b0, 32'd0);
      tick();
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t1_e0_busy",   {16'd0, busy_mask}, 32'h0008);
      chk("t1_e0_addr",   {28'd0, wb_addr}, 32'd0);
      chk("t1_e0_idle",   {31'd0, idle}, 32'd0);
      tick();
      chk("t1_e1_addr",   {28'd0, wb_addr}, 32'd3);
      chk("t1_e1_data",   wb_data, 32'h0000_00AA);
      chk("t1_e1_trig",   {31'd0, wb_trigger}, 32'd0);
      chk("t1_e1_busy",   {16'd0, busy_mask}, 32'h0008);
      tick();
      chk("t1_e2_trig",   {31'd0, wb_trigger}, 32'd1);
      chk("t1_e2_busy",   {16'd0, busy_mask}, 32'h0000);
      chk("t1_e2_pc_wr",  {31'd0, pc_wr}, 32'd0);
      tick();
      chk("t1_e3_idle",   {31'd0, idle}, 32'd1);

      // Back-to-back writes to r5: toggles 3 cycles apart, in order
      clear_log();
      set_res(1'b1, 1'b1, 4'd5, 32'd1, 1'b0, 32'd0);
      tick();
      set_res(1'b1, 1'b1, 4'd5, 32'd2, 1'b0, 32'd0);
      tick();
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t2_busy",      {16'd0, busy_mask}, 32'h0020);
      wait_idle(30);
      chk("t2_ntog",      tog_data.size(), 32'd2);
      if (tog_data.size() >= 2) begin
         chk("t2_data0",    tog_data[0], 32'd1);
         chk("t2_data1",    tog_data[1], 32'd2);
         chk("t2_spacing",  tog_cyc[1] - tog_cyc[0], 32'd3);
         chk("t2_busy_at0", {31'd0, tog_busy[0][5]}, 32'd1);
         chk("t2_busy_at1", {31'd0, tog_busy[1][5]}, 32'd0);
      end

      // Fill: producer pushes r1..r6 while the FSM drains one per 3 cycles
      clear_log();
      step = 0;
      for (int k = 0; k < 6; k++) begin
         set_res(1'b1, 1'b1, 4'(k + 1), 32'(k + 1) * 32'h11, 1'b0, 32'd0);
         accepted = 1'b0;
         while (!accepted && step < 40) begin
            acc_now = res_ready;
            tick();
            step++;
            if (acc_now) accepted = 1'b1;
         end
         acc_tick[k] = step;
         if (k == 4) begin
            chk("t3_full_ready", {31'd0, res_ready}, 32'd0);
            chk("t3_full_busy",  {16'd0, busy_mask}, 32'h003C);
         end
      end
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t3_acc_e",     acc_tick[4], 32'd5);
      chk("t3_acc_f",     acc_tick[5], 32'd7);
      wait_idle(60);
      chk("t3_ntog",      tog_addr.size(), 32'd6);
      if (tog_addr.size() >= 6) begin
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("t3_order_addr%0d", k), {28'd0, tog_addr[k]}, 32'(k + 1));
            chk($sformatf("t3_order_data%0d", k), tog_data[k], 32'(k + 1) * 32'h11);
         end
      end

      // CPSR-only entry followed by a PC write (trigger is 1 after 9 toggles)
      clear_log();
      set_res(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 32'h6000_0000);
      tick();
      set_res(1'b1, 1'b1, 4'hF, 32'h0000_0100, 1'b0, 32'd0);
      tick();
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t4_e1_cpsr",   cpsr_out, 32'd0);
      chk("t4_e1_trig",   {31'd0, wb_trigger}, 32'd1);
      tick();
      chk("t4_e2_cpsr",   cpsr_out, 32'h6000_0000);
      chk("t4_e2_trig",   {31'd0, wb_trigger}, 32'd1);
      chk("t4_e2_pc_wr",  {31'd0, pc_wr}, 32'd0);
      tick();
      chk("t4_e3_addr",   {28'd0, wb_addr}, 32'hF);
      chk("t4_e3_pc_wr",  {31'd0, pc_wr}, 32'd0);
      tick();
      chk("t4_e4_trig",   {31'd0, wb_trigger}, 32'd0);
      chk("t4_e4_pc_wr",  {31'd0, pc_wr}, 32'd1);
      tick();
      chk("t4_e5_pc_wr",  {31'd0, pc_wr}, 32'd0);
      chk("t4_ntog",      tog_pc.size(), 32'd1);
      wait_idle(20);

      // Reset while in HOLD with trigger high; queued r8/r9 must never issue
      set_res(1'b1, 1'b1, 4'd7, 32'h77, 1'b0, 32'd0);
      tick();
      set_res(1'b1, 1'b1, 4'd8, 32'h88, 1'b0, 32'd0);
      tick();
      set_res(1'b1, 1'b1, 4'd9, 32'h99, 1'b0, 32'd0);
      tick();
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t5_pre_trig",  {31'd0, wb_trigger}, 32'd1);
      chk("t5_pre_busy",  {16'd0, busy_mask}, 32'h0300);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_trig",  {31'd0, wb_trigger}, 32'd0);
      chk("t5_rst_addr",  {28'd0, wb_addr}, 32'd0);
      chk("t5_rst_data",  wb_data, 32'd0);
      chk("t5_rst_cpsr",  cpsr_out, 32'd0);
      chk("t5_rst_busy",  {16'd0, busy_mask}, 32'd0);
      chk("t5_rst_ready", {31'd0, res_ready}, 32'd1);
      chk("t5_rst_idle",  {31'd0, idle}, 32'd1);
      chk("t5_rst_pc_wr", {31'd0, pc_wr}, 32'd0);
      clear_log();
      tick();
      tick();
      rst_n = 1'b1;
      repeat (15) tick();
      chk("t5_no_issue",  tog_data.size(), 32'd0);
      chk("t5_post_trig", {31'd0, wb_trigger}, 32'd0);
      chk("t5_post_idle", {31'd0, idle}, 32'd1);

`ifdef REGBANK_WB_FORWARD_EN
      // Forwarding: newest pending r2 wins
      fwd_addr = 4'd2;
      set_res(1'b1, 1'b1, 4'd2, 32'd7, 1'b0, 32'd0);
      tick();
      set_res(1'b1, 1'b1, 4'd2, 32'd9, 1'b0, 32'd0);
      chk("t6_hit_one",   {31'd0, fwd_hit}, 32'd1);
      chk("t6_data_one",  fwd_data, 32'd7);
      tick();
      set_res(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      chk("t6_hit_two",   {31'd0, fwd_hit}, 32'd1);
      chk("t6_data_two",  fwd_data, 32'd9);
      fwd_addr = 4'd4;
      #1;
      chk("t6_miss_hit",  {31'd0, fwd_hit}, 32'd0);
      chk("t6_miss_data", fwd_data, 32'd0);
      fwd_addr = 4'd2;
      wait_idle(30);
      chk("t6_drained",   {31'd0, fwd_hit}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
